// File: rtl/shift_sequencer.sv
// shift_sequencer: shares one 4-bit shift step between two requesters.
// Requesters are arbitrated round-robin. The winning operand, mode and count
// are latched. The step is then applied once per clock for `cnt` cycles, and
// the result is returned with the owner's ID over a valid/ready handshake.
// Optional build macro: SHIFT_SEQ_ZERO_SKIP_EN. When it is defined, a zero
// count goes from IDLE straight to DONE, so the result appears one cycle after
// accept.
module shift_sequencer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [2:0]       req0_mode,
  input  logic [CNT_W-1:0] req0_cnt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [2:0]       req1_mode,
  input  logic [CNT_W-1:0] req1_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_r,
  output logic             out_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic             last_grant;
  logic             run;        // low for the first cycle after reset so no accept happens then
  logic [3:0]       data_reg;
  logic [2:0]       mode_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             id_reg;

  logic             grant;
  logic             acc0;
  logic             acc1;
  logic [3:0]       sel_a;
  logic [2:0]       sel_mode;
  logic [CNT_W-1:0] sel_cnt;

  // One step of the shared shifter datapath
  function automatic logic [3:0] shift_step(input logic [3:0] d, input logic [2:0] mode);
    logic [3:0] r;
    case (mode)
      3'b001:  r = {d[2:0], 1'b0};
      3'b010:  r = {1'b0, d[3:1]};
      3'b011:  r = {d[3], d[3:1]};
      3'b100:  r = {d[2:0], d[3]};
      3'b101:  r = {d[0], d[3:1]};
      3'b110:  r = 4'b0000;
      default: r = d;
    endcase
    return r;
  endfunction

  // Round-robin grant: a tie goes to the requester that did not win last time
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
  end

  assign req0_ready = run && (state == IDLE) && !grant;
  assign req1_ready = run && (state == IDLE) && grant;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign sel_a      = acc1 ? req1_a    : req0_a;
  assign sel_mode   = acc1 ? req1_mode : req0_mode;
  assign sel_cnt    = acc1 ? req1_cnt  : req0_cnt;

  assign out_r = data_reg;
  assign out_id = id_reg;
  assign busy   = (state != IDLE);

  // Control FSM with the operand/count registers and the registered out_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      run        <= 1'b0;
      data_reg   <= 4'b0000;
      mode_reg   <= 3'b000;
      cnt_reg    <= '0;
      id_reg     <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        IDLE: begin
          if (acc0 || acc1) begin
            data_reg   <= sel_a;
            mode_reg   <= sel_mode;
            cnt_reg    <= sel_cnt;
            id_reg     <= acc1;
            last_grant <= acc1;
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
            if (sel_cnt == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
`else
            state <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          if (cnt_reg != '0) begin
            data_reg <= shift_step(data_reg, mode_reg);
            cnt_reg  <= cnt_reg - CNT_W'(1);
          end else begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with hand-computed expected results.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = 4'd0, req1_a = 4'd0;
  logic [2:0] req0_mode = 3'd0, req1_mode = 3'd0;
  logic [2:0] req0_cnt = 3'd0, req1_cnt = 3'd0;
  logic       out_valid, out_ready = 1'b0;
  logic [3:0] out_r;
  logic       out_id;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  shift_sequencer #(.CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_mode(req0_mode), .req0_cnt(req0_cnt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_mode(req1_mode), .req1_cnt(req1_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Present a request on port n and hold it until accepted; returns accept cycle
  task automatic send(input int n, input logic [3:0] a, input logic [2:0] m,
                      input logic [2:0] c, output int acc_cyc);
    bit got;
    got = 0;
    acc_cyc = -1;
    if (n == 0) begin req0_a = a; req0_mode = m; req0_cnt = c; req0_valid = 1'b1; end
    else        begin req1_a = a; req1_mode = m; req1_cnt = c; req1_valid = 1'b1; end
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) begin
        got = 1;
        acc_cyc = cyc;
      end
      step();
    end
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (!got) check("accept_timeout", 0, 1);
  endtask

  // Wait at negedges for out_valid; returns the cycle it was first seen
  task automatic wait_out(output int vcyc);
    bit got;
    got = 0;
    vcyc = -1;
    for (int i = 0; i < 30 && !got; i++) begin
      #1;
      if (out_valid) begin got = 1; vcyc = cyc; end
      else step();
    end
    if (!got) check("out_timeout", 0, 1);
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Full single transaction with result, owner and latency checks
  task automatic run_op(input string tag, input int n, input logic [3:0] a,
                        input logic [2:0] m, input logic [2:0] c,
                        input logic [3:0] exp_r, input int exp_lat);
    int ca, cv;
    send(n, a, m, c, ca);
    wait_out(cv);
    check({tag, "_r"}, out_r, exp_r);
    check({tag, "_id"}, out_id, n[0]);
    check({tag, "_lat"}, cv - ca, exp_lat);
    take_out();
  endtask

  initial begin
    int ca, cv, seen;
    // Reset state, with a request pending that must not be accepted
    req0_valid = 1'b1;
    step();
    step();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_id", out_id, 0);
    check("rst_busy", busy, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // ROL 1001 by 3 -> 1100, latency cnt+2, then hold under backpressure
    send(0, 4'b1001, 3'b100, 3'd3, ca);
    wait_out(cv);
    check("rol3_lat", cv - ca, 5);
    check("rol3_r", out_r, 4'b1100);
    check("rol3_id", out_id, 0);
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_r", out_r, 4'b1100);
      check("hold_ready0", req0_ready, 0);
      check("hold_ready1", req1_ready, 0);
    end
    req1_valid = 1'b0;
    take_out();
    #1;
    check("post_done_valid", out_valid, 0);
    check("post_done_busy", busy, 0);

    // Tie after reset: req0 first, then req1, then the next tie goes back to req0
    do_reset();
    step();
    req0_a = 4'b1000; req0_mode = 3'b010; req0_cnt = 3'd2; req0_valid = 1'b1;
    req1_a = 4'b1000; req1_mode = 3'b011; req1_cnt = 3'd2; req1_valid = 1'b1;
    #1;
    check("tie1_ready0", req0_ready, 1);
    check("tie1_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    #1;
    check("shift_ready1", req1_ready, 0);
    check("shift_busy", busy, 1);
    wait_out(cv);
    check("lsr_r", out_r, 4'b0010);
    check("lsr_id", out_id, 0);
    take_out();
    #1;
    check("rr_ready1", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    wait_out(cv);
    check("asr_r", out_r, 4'b1110);
    check("asr_id", out_id, 1);
    take_out();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("tie2_ready0", req0_ready, 1);
    check("tie2_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_out(cv);
    check("tie2_r", out_r, 4'b0010);
    check("tie2_id", out_id, 0);
    take_out();

    // Maximum count and rotate wrap
    run_op("lsl7", 1, 4'b0110, 3'b001, 3'd7, 4'b0000, 9);
    run_op("ror5", 1, 4'b0110, 3'b101, 3'd5, 4'b0011, 7);

    // Zero count: operand returned unchanged
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
    run_op("cnt0", 0, 4'b0111, 3'b110, 3'd0, 4'b0111, 1);
`else
    run_op("cnt0", 0, 4'b0111, 3'b110, 3'd0, 4'b0111, 2);
`endif

    // Reset in SHIFT with cnt_reg = 4 discards the operation
    send(0, 4'b0001, 3'b100, 3'd6, ca);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_r", out_r, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      #1;
      if (out_valid) seen++;
    end
    check("midrst_no_stale", seen, 0);
    run_op("after_rst", 1, 4'b0011, 3'b010, 3'd1, 4'b0001, 3);

    // Inputs changed after accept are ignored
    send(0, 4'b0011, 3'b100, 3'd2, ca);
    req0_a = 4'b1111;
    req0_mode = 3'b110;
    wait_out(cv);
    check("latched_r", out_r, 4'b1100);
    check("latched_lat", cv - ca, 4);
    take_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
